// File: rtl/hazard_detect_pkg.sv
// Shared definitions for the decode-stage RAW hazard detector:
// instruction field positions, tracker slot layout and slot record type.
package hazard_detect_pkg;

   localparam int RS_HI = 10;
   localparam int RS_LO = 8;
   localparam int RT_HI = 7;
   localparam int RT_LO = 5;

   localparam int SLOT_EX   = 0;
   localparam int SLOT_MEM  = 1;
   localparam int SLOT_WB   = 2;
   localparam int NUM_SLOTS = 3;

   typedef struct packed {
      logic       v;
      logic [2:0] dst;
   } slot_t;

endpackage

// File: rtl/hazard_detect_if.sv
// Decode-side bundle between the IF/ID stage and the hazard detector.
// The master drives the instruction and pipeline controls; the slave answers with the stall.
interface hazard_detect_if #(
   parameter int CNT_W = 16
) ();

   logic             id_valid;
   logic [15:0]      id_instr;
   logic [1:0]       id_num_rd;
   logic             id_wr_en;
   logic [2:0]       id_wr_reg;
   logic             flush;
   logic             mem_stall;
   logic             stall;
   logic [CNT_W-1:0] stall_cnt;
   logic [7:0]       busy_mask;

   modport master (
      output id_valid, id_instr, id_num_rd, id_wr_en, id_wr_reg, flush, mem_stall,
      input  stall, stall_cnt, busy_mask
   );

   modport slave (
      input  id_valid, id_instr, id_num_rd, id_wr_en, id_wr_reg, flush, mem_stall,
      output stall, stall_cnt, busy_mask
   );

endinterface

// File: rtl/hazard_detect_wr_tracker.sv
// Three-deep record of destination registers in flight through EX, MEM and WB.
// The whole record freezes while the memory side holds the pipeline.
module wr_tracker
   import hazard_detect_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        hold,
   input  slot_t                       new_slot,
   output slot_t [NUM_SLOTS-1:0]       slots
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slots <= '0;
      end else if (!hold) begin
         slots[SLOT_WB]  <= slots[SLOT_MEM];
         slots[SLOT_MEM] <= slots[SLOT_EX];
         slots[SLOT_EX]  <= new_slot;
      end
   end

endmodule

// File: rtl/hazard_detect.sv
// Decode-stage RAW hazard detector: compares ID sources against in-flight writers,
// raises stall, and counts hazard-stall cycles with saturation.
module hazard_detect
   import hazard_detect_pkg::*;
#(
   parameter bit WB_BYPASS = 1'b1,
   parameter int CNT_W     = 16
) (
   input logic            clk,
   input logic            rst,
   hazard_detect_if.slave bus
);

   slot_t [NUM_SLOTS-1:0] slots;
   slot_t                 new_slot;
   logic [2:0]            rs;
   logic [2:0]            rt;
   logic                  match_rs;
   logic                  match_rt;
   logic                  hazard;
   logic [7:0]            busy;
   logic [CNT_W-1:0]      cnt_q;
   logic                  unused_instr_bits;

   assign rs = bus.id_instr[RS_HI:RS_LO];
   assign rt = bus.id_instr[RT_HI:RT_LO];
   assign unused_instr_bits = ^{bus.id_instr[15:11], bus.id_instr[4:0]};

   // The WB slot only matters when the register file cannot bypass write to read.
   always_comb begin
      match_rs = 1'b0;
      match_rt = 1'b0;
      busy     = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (slots[i].v) begin
            busy[slots[i].dst] = 1'b1;
            if ((i != SLOT_WB) || !WB_BYPASS) begin
               if (slots[i].dst == rs) match_rs = 1'b1;
               if (slots[i].dst == rt) match_rt = 1'b1;
            end
         end
      end
   end

   assign hazard = bus.id_valid && !bus.flush &&
                   (((bus.id_num_rd >= 2'd1) && match_rs) ||
                    ((bus.id_num_rd >= 2'd2) && match_rt));

   assign new_slot.v   = bus.id_valid && bus.id_wr_en && !bus.flush && !hazard;
   assign new_slot.dst = bus.id_wr_reg;

   wr_tracker u_tracker (
      .clk      (clk),
      .rst      (rst),
      .hold     (bus.mem_stall),
      .new_slot (new_slot),
      .slots    (slots)
   );

   // Only genuine hazard cycles count; memory-only stalls are excluded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (hazard && !bus.mem_stall && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.stall     = hazard || bus.mem_stall;
   assign bus.stall_cnt = cnt_q;
   assign bus.busy_mask = busy;

endmodule

// File: tb/tb_hazard_detect.sv
// Scoreboard bench driving one stimulus stream into a bypassing and a non-bypassing
// detector, each checked against an age-based model of in-flight writers.
module tb_hazard_detect;
   import hazard_detect_pkg::*;

   localparam int CW     = 5;
   localparam int CNTMAX = (1 << CW) - 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        t_valid;
   logic [15:0] t_instr;
   logic [1:0]  t_num;
   logic        t_we;
   logic [2:0]  t_wr;
   logic        t_flush;
   logic        t_ms;

   always #5 clk = ~clk;

   hazard_detect_if #(.CNT_W(CW)) bus_b ();
   hazard_detect_if #(.CNT_W(CW)) bus_n ();

   assign bus_b.id_valid  = t_valid;
   assign bus_b.id_instr  = t_instr;
   assign bus_b.id_num_rd = t_num;
   assign bus_b.id_wr_en  = t_we;
   assign bus_b.id_wr_reg = t_wr;
   assign bus_b.flush     = t_flush;
   assign bus_b.mem_stall = t_ms;
   assign bus_n.id_valid  = t_valid;
   assign bus_n.id_instr  = t_instr;
   assign bus_n.id_num_rd = t_num;
   assign bus_n.id_wr_en  = t_we;
   assign bus_n.id_wr_reg = t_wr;
   assign bus_n.flush     = t_flush;
   assign bus_n.mem_stall = t_ms;

   hazard_detect #(.WB_BYPASS(1'b1), .CNT_W(CW)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   hazard_detect #(.WB_BYPASS(1'b0), .CNT_W(CW)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

   typedef struct {
      logic          stall;
      logic [CW-1:0] cnt;
      logic [7:0]    busy;
   } exp_t;

   // A writer is remembered by the advance index at which it entered EX.
   typedef struct {
      int dst;
      int k;
   } wr_t;

   exp_t expq0[$];
   exp_t expq1[$];
   wr_t  wq0[$];
   wr_t  wq1[$];
   int   adv = 0;
   int   cnt[2];
   int   checks = 0;
   int   errors = 0;

   function automatic bit inFlight(int d, int r, int lim);
      wr_t q[$];
      if (d == 0) q = wq0;
      else        q = wq1;
      foreach (q[i]) begin
         if (q[i].dst == r && (adv - 1 - q[i].k) < lim) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit modelHazard(int d);
      int nsrc;
      int lim;
      int rs;
      int rt;
      nsrc = (t_num == 2'd0) ? 0 : (t_num == 2'd1) ? 1 : 2;
      lim  = (d == 0) ? 2 : 3;
      rs   = int'(t_instr[10:8]);
      rt   = int'(t_instr[7:5]);
      if (!t_valid || t_flush) return 1'b0;
      return (nsrc >= 1 && inFlight(d, rs, lim)) || (nsrc >= 2 && inFlight(d, rt, lim));
   endfunction

   function automatic logic [7:0] modelBusy(int d);
      logic [7:0] b;
      b = '0;
      for (int r = 0; r < 8; r++) b[r] = inFlight(d, r, 3);
      return b;
   endfunction

   task automatic clearModel();
      wq0.delete();
      wq1.delete();
      cnt[0] = 0;
      cnt[1] = 0;
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [15:0] instr,
                                input logic [1:0] num, input logic we, input logic [2:0] wr,
                                input logic fl, input logic ms);
      bit   h[2];
      exp_t e;
      rst = r; t_valid = v; t_instr = instr; t_num = num;
      t_we = we; t_wr = wr; t_flush = fl; t_ms = ms;
      if (r) clearModel();
      for (int d = 0; d < 2; d++) begin
         h[d]    = modelHazard(d);
         e.stall = h[d] || ms;
         e.cnt   = cnt[d][CW-1:0];
         e.busy  = modelBusy(d);
         if (d == 0) expq0.push_back(e);
         else        expq1.push_back(e);
      end
      @(posedge clk);
      if (rst) begin
         clearModel();
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (h[d] && !ms && cnt[d] < CNTMAX) cnt[d]++;
         end
         if (!ms) begin
            if (v && we && !fl && !h[0]) wq0.push_back('{dst: int'(wr), k: adv});
            if (v && we && !fl && !h[1]) wq1.push_back('{dst: int'(wr), k: adv});
            adv++;
            while (wq0.size() > 0 && (adv - 1 - wq0[0].k) >= 3) void'(wq0.pop_front());
            while (wq1.size() > 0 && (adv - 1 - wq1[0].k) >= 3) void'(wq1.pop_front());
         end
      end
      #1;
   endtask

   task automatic checkOutput(input string name, input exp_t e, input logic s,
                              input logic [CW-1:0] c, input logic [7:0] b);
      checks += 3;
      if (s !== e.stall) begin
         errors++;
         $display("[TB] FAIL %s.stall got %0b expected %0b at %0t", name, s, e.stall, $time);
      end
      if (c !== e.cnt) begin
         errors++;
         $display("[TB] FAIL %s.stall_cnt got %0d expected %0d at %0t", name, c, e.cnt, $time);
      end
      if (b !== e.busy) begin
         errors++;
         $display("[TB] FAIL %s.busy_mask got %b expected %b at %0t", name, b, e.busy, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq0.size() > 0) begin
            e = expq0.pop_front();
            checkOutput("bypass", e, bus_b.stall, bus_b.stall_cnt, bus_b.busy_mask);
         end
         if (expq1.size() > 0) begin
            e = expq1.pop_front();
            checkOutput("no_bypass", e, bus_n.stall, bus_n.stall_cnt, bus_n.busy_mask);
         end
      end
   end

   function automatic logic [15:0] mk(input logic [2:0] rs, input logic [2:0] rt);
      return {5'b0, rs, rt, 5'b0};
   endfunction

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, 0, 16'h0, 2'd0, 0, 3'd0, 0, 0);
   endtask

   task automatic produce(input logic [2:0] wr);
      applyStimulus(0, 1, mk(3'd0, 3'd0), 2'd0, 1, wr, 0, 0);
   endtask

   initial begin
      rst = 1'b1; t_valid = 0; t_instr = '0; t_num = '0; t_we = 0; t_wr = '0; t_flush = 0; t_ms = 0;
      @(posedge clk);
      #1;
      applyStimulus(1, 0, 16'h0, 2'd0, 0, 3'd0, 0, 0);
      applyStimulus(1, 1, mk(3'd1, 3'd2), 2'd2, 1, 3'd1, 0, 1);
      idle(2);

      // Adjacent dependency: ADD r3 then ADD r4,r3,r1 held in ID.
      applyStimulus(0, 1, mk(3'd1, 3'd2), 2'd2, 1, 3'd3, 0, 0);
      repeat (4) applyStimulus(0, 1, mk(3'd3, 3'd1), 2'd2, 1, 3'd4, 0, 0);
      idle(4);

      // Dependency at distance 3.
      produce(3'd6);
      repeat (2) applyStimulus(0, 1, mk(3'd0, 3'd0), 2'd0, 0, 3'd0, 0, 0);
      repeat (2) applyStimulus(0, 1, mk(3'd6, 3'd0), 2'd1, 0, 3'd0, 0, 0);
      idle(4);

      // Second-source match counts only when two sources are read.
      produce(3'd5);
      repeat (3) applyStimulus(0, 1, mk(3'd0, 3'd5), 2'd2, 0, 3'd0, 0, 0);
      idle(4);
      produce(3'd5);
      repeat (2) applyStimulus(0, 1, mk(3'd0, 3'd5), 2'd1, 0, 3'd0, 0, 0);
      idle(4);

      // Flush overrides a hazard; mem_stall freezes everything.
      produce(3'd2);
      applyStimulus(0, 1, mk(3'd2, 3'd0), 2'd1, 1, 3'd7, 1, 0);
      idle(1);
      produce(3'd1);
      repeat (4) applyStimulus(0, 1, mk(3'd1, 3'd0), 2'd1, 1, 3'd7, 0, 1);
      repeat (3) applyStimulus(0, 1, mk(3'd1, 3'd0), 2'd1, 1, 3'd7, 0, 0);
      idle(4);

      // Drive the counter into saturation.
      for (int i = 0; i < 20; i++) begin
         produce(3'(i));
         repeat (3) applyStimulus(0, 1, mk(3'(i), 3'd0), 2'd3, 0, 3'd0, 0, 0);
      end
      idle(2);

      // Reset in the middle of a hazard stall.
      produce(3'd3);
      applyStimulus(0, 1, mk(3'd3, 3'd0), 2'd1, 0, 3'd0, 0, 0);
      applyStimulus(1, 1, mk(3'd3, 3'd0), 2'd1, 0, 3'd0, 0, 0);
      applyStimulus(0, 1, mk(3'd3, 3'd0), 2'd1, 1, 3'd3, 0, 0);
      idle(2);

      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0),
                       ($urandom_range(0, 7) != 0),
                       16'($urandom),
                       2'($urandom_range(0, 3)),
                       1'($urandom),
                       3'($urandom_range(0, 7)),
                       ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0));
      end
      idle(2);

      checks++;
      if (expq0.size() != 0 || expq1.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain got %0d/%0d pending expected 0/0",
                  expq0.size(), expq1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
